// File: rtl/fpga_interleaved_ram_mb.sv
// Word-interleaved multi-bank RAM with an optional output register and an optional
// zero-initialisation pass (macro FPGA_RAM_ZERO_INIT_EN).
module fpga_interleaved_ram_mb #(
  parameter int NB_BANKS        = 4,
  parameter int BANK_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int OUT_REG         = 0
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         req_i,
  output logic                                         gnt_o,
  input  logic                                         we_i,
  input  logic [DATA_WIDTH/8-1:0]                      be_i,
  input  logic [$clog2(NB_BANKS)+BANK_ADDR_WIDTH-1:0]  addr_i,
  input  logic [DATA_WIDTH-1:0]                        wdata_i,
  output logic [DATA_WIDTH-1:0]                        rdata_o,
  output logic                                         rvalid_o,
  output logic                                         init_done_o
);

  localparam int SEL_W    = $clog2(NB_BANKS);
  localparam int ADDR_W   = SEL_W + BANK_ADDR_WIDTH;
  localparam int BANK_W   = (SEL_W > 0) ? SEL_W : 1;
  localparam int NB_BYTES = DATA_WIDTH / 8;
  localparam int ROWS     = 1 << BANK_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, INIT, READY} state_e;

  state_e                     state_q;
  logic [BANK_ADDR_WIDTH-1:0] row_q;
  logic                       init_done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      row_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          row_q <= '0;
`ifdef FPGA_RAM_ZERO_INIT_EN
          state_q <= INIT;
`else
          state_q     <= READY;
          init_done_q <= 1'b1;
`endif
        end
        INIT: begin
          row_q <= row_q + 1'b1;
          if (row_q == {BANK_ADDR_WIDTH{1'b1}}) begin
            state_q     <= READY;
            init_done_q <= 1'b1;
          end
        end
        READY:   init_done_q <= 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign init_done_o = init_done_q;
  assign gnt_o       = init_done_q;

  logic init_we;
`ifdef FPGA_RAM_ZERO_INIT_EN
  assign init_we = (state_q == INIT);
`else
  assign init_we = 1'b0;
`endif

  logic [BANK_W-1:0]          bank;
  logic [BANK_ADDR_WIDTH-1:0] row;

  generate
    if (SEL_W > 0) begin : g_sel
      assign bank = addr_i[SEL_W-1:0];
      assign row  = addr_i[ADDR_W-1:SEL_W];
    end else begin : g_nosel
      assign bank = '0;
      assign row  = addr_i;
    end
  endgenerate

  logic xfer, wr, rd;
  assign xfer = req_i && init_done_q;
  assign wr   = xfer && we_i;
  assign rd   = xfer && !we_i;

  // Each bank keeps its own read register; it only changes on a read to that bank,
  // which lets write responses leave rdata_o untouched.
  logic [DATA_WIDTH-1:0] bank_rd [NB_BANKS];

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [ROWS];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  sel;

    assign sel = (bank == BANK_W'(b));

    always_ff @(posedge clk_i) begin
      if (init_we) begin
        mem_q[row_q] <= '0;
      end else if (wr && sel) begin
        for (int k = 0; k < NB_BYTES; k++) begin
          if (be_i[k]) mem_q[row][k*8 +: 8] <= wdata_i[k*8 +: 8];
        end
      end
      if (rd && sel) rd_q <= mem_q[row];
    end

    assign bank_rd[b] = rd_q;
  end

  logic              v1_q;
  logic              have_rd_q;
  logic [BANK_W-1:0] rbank_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      have_rd_q <= 1'b0;
      rbank_q   <= '0;
    end else begin
      v1_q <= xfer;
      if (rd) begin
        rbank_q   <= bank;
        have_rd_q <= 1'b1;
      end
    end
  end

  // Output mux follows the registered bank of the last read, never the live request.
  logic [DATA_WIDTH-1:0] rd_mux;
  assign rd_mux = have_rd_q ? bank_rd[rbank_q] : '0;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  rd1_q;
      logic                  rv2_q;
      logic [DATA_WIDTH-1:0] rdata2_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          rd1_q    <= 1'b0;
          rv2_q    <= 1'b0;
          rdata2_q <= '0;
        end else begin
          rd1_q <= rd;
          rv2_q <= v1_q;
          if (v1_q && rd1_q) rdata2_q <= rd_mux;
        end
      end

      assign rvalid_o = rv2_q;
      assign rdata_o  = rdata2_q;
    end else begin : g_noreg
      assign rvalid_o = v1_q;
      assign rdata_o  = rd_mux;
    end
  endgenerate

endmodule

// File: tb/tb_fpga_interleaved_ram_mb.sv
// Bench for fpga_interleaved_ram_mb: one instance per OUT_REG setting on shared stimulus,
// checked every cycle against a flat word-array model of the memory.
module tb_fpga_interleaved_ram_mb;

  localparam int NB  = 4;
  localparam int BAW = 4;
  localparam int DW  = 32;
  localparam int AW  = 6;
  localparam int N   = 64;
`ifdef FPGA_RAM_ZERO_INIT_EN
  localparam int LAT = 17;
  localparam bit ZI  = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit ZI  = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [3:0]    be = 4'h0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;

  logic          gnt0, rvalid0, done0, gnt1, rvalid1, done1;
  logic [DW-1:0] rdata0, rdata1;

  always #5 clk = ~clk;

  fpga_interleaved_ram_mb #(.NB_BANKS(NB), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW), .OUT_REG(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt0), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata0), .rvalid_o(rvalid0), .init_done_o(done0));

  fpga_interleaved_ram_mb #(.NB_BANKS(NB), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW), .OUT_REG(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt1), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata1), .rvalid_o(rvalid1), .init_done_o(done1));

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bm(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Model: flat word memory with per-byte "known" flags, plus the two response views.
  logic [31:0] ref_mem [N];
  logic [3:0]  kn [N];
  int          cnt;
  logic        m_rv0, m_rd0, m_rv1;
  logic [31:0] m_last0, m_last1;
  logic [3:0]  m_mask0, m_mask1;
  logic        xfer;

  initial begin
    for (int i = 0; i < N; i++) begin
      ref_mem[i] = '0;
      kn[i] = 4'h0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0;
      m_rv0 = 1'b0; m_rd0 = 1'b0; m_rv1 = 1'b0;
      m_last0 = '0; m_last1 = '0;
      m_mask0 = 4'hF; m_mask1 = 4'hF;
      if (ZI) begin
        for (int i = 0; i < N; i++) begin
          ref_mem[i] = '0;
          kn[i] = 4'hF;
        end
      end
    end else begin
      xfer = req && (cnt >= LAT);
      m_rv1 = m_rv0;
      if (m_rv0 && m_rd0) begin
        m_last1 = m_last0;
        m_mask1 = m_mask0;
      end
      m_rv0 = xfer;
      m_rd0 = xfer && !we;
      if (xfer && !we) begin
        m_last0 = ref_mem[addr];
        m_mask0 = kn[addr];
      end
      if (xfer && we) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) begin
            ref_mem[addr][k*8 +: 8] = wdata[k*8 +: 8];
            kn[addr][k] = 1'b1;
          end
        end
      end
      if (cnt < 1000) cnt++;
    end
  end

  bit chk_en = 1'b0;
  logic [31:0] cap0 [$];
  logic [31:0] cap1 [$];

  always @(negedge clk) begin
    if (rvalid0) cap0.push_back(rdata0);
    if (rvalid1) cap1.push_back(rdata1);
    if (chk_en) begin
      chk("gnt0", {31'd0, gnt0}, {31'd0, (cnt >= LAT)});
      chk("gnt1", {31'd0, gnt1}, {31'd0, (cnt >= LAT)});
      chk("done0", {31'd0, done0}, {31'd0, (cnt >= LAT)});
      chk("done1", {31'd0, done1}, {31'd0, (cnt >= LAT)});
      chk("rvalid0", {31'd0, rvalid0}, {31'd0, m_rv0});
      chk("rvalid1", {31'd0, rvalid1}, {31'd0, m_rv1});
      if (m_mask0 != 4'h0) chk("rdata0", rdata0 & bm(m_mask0), m_last0 & bm(m_mask0));
      if (m_mask1 != 4'h0) chk("rdata1", rdata1 & bm(m_mask1), m_last1 & bm(m_mask1));
    end
  end

  task automatic xf(input logic w, input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk); #1;
      req = 1'b0; we = 1'b0; be = 4'h0;
    end
  endtask

  task automatic wait_init();
    int n = 0;
    while (!(done0 && done1) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_latency", n, LAT);
  endtask

  task automatic reset_pulse_checks();
    #1;
    chk("rst_rvalid0", {31'd0, rvalid0}, 32'd0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    reset_pulse_checks();
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_init();

    // Read every address once.
    cap0.delete(); cap1.delete();
    for (int a = 0; a < N; a++) xf(1'b0, 4'h0, AW'(a), 32'h0);
    idle(4);
    chk("all_rd_count0", cap0.size(), N);
    chk("all_rd_count1", cap1.size(), N);
`ifdef FPGA_RAM_ZERO_INIT_EN
    begin
      int nz = 0;
      foreach (cap0[i]) if (cap0[i] != 32'h0) nz++;
      chk("zero_init_nonzero", nz, 0);
    end
`endif

    // Interleaving across the four banks.
    cap0.delete(); cap1.delete();
    xf(1'b1, 4'hF, 6'd0, 32'h11111111);
    xf(1'b1, 4'hF, 6'd1, 32'h22222222);
    xf(1'b1, 4'hF, 6'd2, 32'h33333333);
    xf(1'b1, 4'hF, 6'd3, 32'h44444444);
    xf(1'b0, 4'h0, 6'd3, 32'h0);
    xf(1'b0, 4'h0, 6'd2, 32'h0);
    xf(1'b0, 4'h0, 6'd1, 32'h0);
    xf(1'b0, 4'h0, 6'd0, 32'h0);
    idle(4);
    chk("il_count0", cap0.size(), 8);
    chk("il_count1", cap1.size(), 8);
    if (cap0.size() == 8 && cap1.size() == 8) begin
      chk("il0_a3", cap0[4], 32'h44444444);
      chk("il0_a2", cap0[5], 32'h33333333);
      chk("il0_a1", cap0[6], 32'h22222222);
      chk("il0_a0", cap0[7], 32'h11111111);
      chk("il1_a3", cap1[4], 32'h44444444);
      chk("il1_a0", cap1[7], 32'h11111111);
    end

    // Byte enables, including an all-zero mask.
    cap0.delete(); cap1.delete();
    xf(1'b1, 4'hF, 6'd5, 32'hAABBCCDD);
    xf(1'b1, 4'h5, 6'd5, 32'h00000000);
    xf(1'b0, 4'h0, 6'd5, 32'h0);
    xf(1'b1, 4'h0, 6'd5, 32'h12345678);
    xf(1'b0, 4'h0, 6'd5, 32'h0);
    idle(4);
    chk("be_count0", cap0.size(), 5);
    if (cap0.size() == 5) begin
      chk("be_partial", cap0[2], 32'hAA00CC00);
      chk("be_zero_mask", cap0[4], 32'hAA00CC00);
    end

    // Read of an address right after writing it.
    cap0.delete(); cap1.delete();
    xf(1'b1, 4'hF, 6'd7, 32'hDEADBEEF);
    xf(1'b0, 4'h0, 6'd7, 32'h0);
    idle(4);
    if (cap0.size() == 2 && cap1.size() == 2) begin
      chk("raw0", cap0[1], 32'hDEADBEEF);
      chk("raw1", cap1[1], 32'hDEADBEEF);
    end else chk("raw_count", cap0.size() + cap1.size(), 4);

    // Latency and rdata hold on a write response.
    xf(1'b0, 4'h0, 6'd0, 32'h0);
    idle(1);
    chk("lat_t1_rv0", {31'd0, rvalid0}, 32'd1);
    chk("lat_t1_rv1", {31'd0, rvalid1}, 32'd0);
    idle(1);
    chk("lat_t2_rv0", {31'd0, rvalid0}, 32'd0);
    chk("lat_t2_rv1", {31'd0, rvalid1}, 32'd1);
    chk("lat_t2_rd1", rdata1, 32'h11111111);
    xf(1'b1, 4'hF, 6'd2, 32'h55555555);
    idle(1);
    chk("wr_hold_rv0", {31'd0, rvalid0}, 32'd1);
    chk("wr_hold_rd0", rdata0, 32'h11111111);
    idle(1);
    chk("wr_hold_rv1", {31'd0, rvalid1}, 32'd1);
    chk("wr_hold_rd1", rdata1, 32'h11111111);
    idle(2);

    // Reset with two reads in flight.
    xf(1'b0, 4'h0, 6'd1, 32'h0);
    xf(1'b0, 4'h0, 6'd2, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    req = 1'b0;
    reset_pulse_checks();
    idle(2);
    rst_n = 1'b1;
    wait_init();
    idle(3);

    // Reset during initialisation (row 5 when zero-init is compiled in).
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    reset_pulse_checks();
    @(negedge clk); #1;
    rst_n = 1'b1;
    wait_init();
    cap0.delete(); cap1.delete();
    for (int a = 0; a < 8; a++) xf(1'b0, 4'h0, AW'(a), 32'h0);
    idle(4);
    chk("post_rst_count0", cap0.size(), 8);
`ifdef FPGA_RAM_ZERO_INIT_EN
    if (cap0.size() == 8) chk("reinit_zero_a0", cap0[0], 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
